// File: rtl/dffsre_bank_ctrl_if.sv
// Request, completion and bank-pin bundle for dffsre_bank_ctrl.
// The slave modport is the controller; the master modport is the requesters plus the bank.
interface dffsre_bank_ctrl_if #(
    parameter int unsigned W = 10
);
    logic         a_valid;
    logic         a_ready;
    logic [W-1:0] a_data;
    logic         b_valid;
    logic         b_ready;
    logic [W-1:0] b_data;
    logic         clr_req;
    logic         preset_req;
    logic         clr_ack;
    logic         preset_ack;
    logic [W-1:0] bank_q;
    logic [W-1:0] bank_d;
    logic         bank_sel;
    logic         bank_e;
    logic         bank_r;
    logic         bank_s;
    logic         busy;
    logic         err;

    modport slave (
        input  a_valid, a_data, b_valid, b_data, clr_req, preset_req, bank_q,
        output a_ready, b_ready, clr_ack, preset_ack, bank_d, bank_sel, bank_e,
               bank_r, bank_s, busy, err
    );

    modport master (
        output a_valid, a_data, b_valid, b_data, clr_req, preset_req, bank_q,
        input  a_ready, b_ready, clr_ack, preset_ack, bank_d, bank_sel, bank_e,
               bank_r, bank_s, busy, err
    );
endinterface

// File: rtl/dffsre_bank_ctrl.sv
// Sequencer/arbiter for a dffsre flop bank: round-robin writes from two requesters,
// timed clear/preset pulses, and a read-back check of every operation against a shadow copy.
module dffsre_bank_ctrl #(
    parameter int unsigned W           = 10,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input logic                clk,
    input logic                rst,
    dffsre_bank_ctrl_if.slave  bus
);
    localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StWrite, StClear, StPreset, StCheck} state_e;
    // Remembers what led into CHECK so the right ack fires; OpNone covers the reset clear.
    typedef enum logic [1:0] {OpNone, OpClr, OpPre, OpWr} op_e;

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    shadow_q, shadow_d;
    logic [W-1:0]    bank_d_q, bank_d_d;
    logic            rr_q, rr_d;   // 0: A wins a tie, 1: B wins a tie
    logic            err_q, err_d;
    logic            bank_r_q, bank_r_d;
    logic            bank_s_q, bank_s_d;
    logic            a_ready, b_ready, clr_ack, preset_ack, mismatch;
    logic            grant_a, grant_b;

    assign grant_a = bus.a_valid && (!bus.b_valid || !rr_q);
    assign grant_b = bus.b_valid && !grant_a;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        bank_d_d   = bank_d_q;
        rr_d       = rr_q;
        err_d      = err_q;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        clr_ack    = 1'b0;
        preset_ack = 1'b0;
        mismatch   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.clr_req) begin
                    state_d = StClear;
                    cnt_d   = HoldLoad;
                    op_d    = OpClr;
                end else if (bus.preset_req) begin
                    state_d = StPreset;
                    cnt_d   = HoldLoad;
                    op_d    = OpPre;
                end else if (grant_a) begin
                    a_ready  = 1'b1;
                    bank_d_d = bus.a_data;
                    shadow_d = bus.a_data;
                    rr_d     = 1'b1;
                    op_d     = OpWr;
                    state_d  = StWrite;
                end else if (grant_b) begin
                    b_ready  = 1'b1;
                    bank_d_d = bus.b_data;
                    shadow_d = bus.b_data;
                    rr_d     = 1'b0;
                    op_d     = OpWr;
                    state_d  = StWrite;
                end
            end
            StWrite: state_d = StCheck;
            StClear: begin
                shadow_d = '0;
                if (cnt_q == '0) state_d = StCheck;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StPreset: begin
                shadow_d = '1;
                if (cnt_q == '0) state_d = StCheck;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StCheck: begin
                mismatch   = (bus.bank_q != shadow_q);
                err_d      = err_q | mismatch;
                clr_ack    = (op_q == OpClr);
                preset_ack = (op_q == OpPre);
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Pins follow the next state so they are clean flop outputs, never both high.
        bank_r_d = (state_d == StClear);
        bank_s_d = (state_d == StPreset);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StClear;
            op_q     <= OpNone;
            cnt_q    <= HoldLoad;
            shadow_q <= '0;
            bank_d_q <= '0;
            rr_q     <= 1'b0;
            err_q    <= 1'b0;
            bank_r_q <= 1'b1;
            bank_s_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            bank_d_q <= bank_d_d;
            rr_q     <= rr_d;
            err_q    <= err_d;
            bank_r_q <= bank_r_d;
            bank_s_q <= bank_s_d;
        end
    end

    assign bus.a_ready    = a_ready;
    assign bus.b_ready    = b_ready;
    assign bus.clr_ack    = clr_ack;
    assign bus.preset_ack = preset_ack;
    assign bus.bank_d     = bank_d_q;
    assign bus.bank_sel   = (state_q == StWrite);
    assign bus.bank_e     = (state_q == StWrite);
    assign bus.bank_r     = bank_r_q;
    assign bus.bank_s     = bank_s_q;
    assign bus.busy       = (state_q != StIdle);
    // Mismatch shows during CHECK itself, then stays latched until reset.
    assign bus.err        = err_q | mismatch;
endmodule
